// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction prefetch queue.
// master: fetch/decode side driving the queue; slave: the queue itself.
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    logic                     fetch_valid;
    logic [XLEN-1:0]          fetch_pc;
    logic [XLEN-1:0]          fetch_instr;
    logic                     fetch_ready;
    logic                     flush;
    logic                     dec_valid;
    logic [XLEN-1:0]          dec_pc;
    logic [XLEN-1:0]          dec_instr;
    logic                     dec_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, flush, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_instr, count, overflow
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, flush, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_instr, count, overflow
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: in-order {pc, instr} FIFO between fetch and
// decode. Absorbs decode stalls, drops everything on redirect (flush), and
// flags pushes attempted while full with a sticky overflow bit.
module fetch_queue #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            ovf;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    // No pass-through when full: a same-cycle pop never frees a slot for push.
    assign push  = bus.fetch_valid & ~full;
    assign pop   = bus.dec_ready & ~empty;

    // Storage write; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            pc_mem[wr_ptr]    <= bus.fetch_pc;
            instr_mem[wr_ptr] <= bus.fetch_instr;
        end
    end

    // Pointer, occupancy and sticky overflow update; flush beats push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
            if (bus.fetch_valid && full)
                ovf <= 1'b1;
        end
    end

    // Head presentation; an empty queue shows pc 0 and a NOP to decode.
    always_comb begin
        bus.fetch_ready = ~full;
        bus.dec_valid   = ~empty;
        bus.dec_pc      = '0;
        bus.dec_instr   = NOP_INSTR;
        if (!empty) begin
            bus.dec_pc    = pc_mem[rd_ptr];
            bus.dec_instr = instr_mem[rd_ptr];
        end
        bus.count    = cnt;
        bus.overflow = ovf;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between the PC counter/IMEM fetch stage and the decode stage.
- Captures {pc, instr} pairs from fetch and presents them in order to decode with a valid/ready handshake.
- Absorbs decode stalls and discards stale entries on control-flow redirects (jump, taken branch, irq).

Parameters:
- XLEN, 32, width of pc and instruction words.
- DEPTH, 4, number of entries; power of two, >= 2.
- NOP_INSTR, 32'h00000013, value driven on dec_instr while the queue is empty.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_valid  input  1  fetch stage presents a valid {fetch_pc, fetch_instr} this cycle.
- fetch_pc  input  XLEN  pc of the fetched instruction.
- fetch_instr  input  XLEN  instruction word read from IMEM.
- fetch_ready  output  1  queue can accept a push this cycle (not full).
- flush  input  1  redirect (jump, taken branch or irq); discard all entries.
- dec_valid  output  1  head entry valid.
- dec_pc  output  XLEN  pc of head entry.
- dec_instr  output  XLEN  instruction of head entry.
- dec_ready  input  1  decode consumes head this cycle.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky: a push was attempted while full.

Behaviour:
- Storage: DEPTH-entry circular buffer; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset (async, while reset=1):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Storage contents need not be cleared.
  - Outputs: fetch_ready=1, dec_valid=0, dec_pc=0, dec_instr=NOP_INSTR.
- push = fetch_valid & fetch_ready. pop = dec_valid & dec_ready.
- fetch_ready = (count != DEPTH), combinational. There is no pass-through when full; a same-cycle pop does not enable a push.
- dec_valid = (count != 0), combinational.
- dec_pc / dec_instr:
  - Non-empty: show the head entry, read combinationally from storage.
  - Empty: dec_pc=0, dec_instr=NOP_INSTR.
- Latency: a pushed entry is visible on dec_* one cycle after the push edge. There is no same-cycle bypass from fetch to decode.
- Push only: write entry at wr_ptr, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (non-empty, not full): both pointers advance and count is unchanged.
- Push and pop together on an empty queue: impossible, because dec_valid=0 prevents the pop; only the push takes effect.
- flush=1 has highest priority at the edge:
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Any same-cycle push and pop are ignored.
  - The cycle after flush: dec_valid=0, fetch_ready=1.
- overflow: set at an edge where fetch_valid=1 and count==DEPTH and flush=0. The fetched word is dropped. overflow holds until reset or flush.
- dec_ready while empty: no effect; the pointers do not move.
- Reset asserted mid-operation: state clears immediately without waiting for an edge. After deassertion the queue behaves as freshly reset.

Test Plan:
- Reset/idle: hold reset 15 ns, then release -> count=0, dec_valid=0, dec_instr=32'h00000013, dec_pc=0, fetch_ready=1, overflow=0.
- Fill and drain (dec_ready=0):
  - Push pc 0,4,8,12 with instr 0xA0..0xA3 on four consecutive edges -> count=4, fetch_ready=0 after the 4th edge, dec_pc=0, dec_instr=0xA0.
  - Then dec_ready=1 for 4 cycles -> dec_pc sequence 0,4,8,12, instr 0xA0..0xA3, then dec_valid=0 and count=0.
- Streaming with wrap: dec_ready=1 constantly, push pc 0..36 step 4 for 10 consecutive cycles -> each entry appears on dec_pc exactly one cycle after its push, count stays 1, pointers wrap past DEPTH with no loss or reorder.
- Overflow: with the queue full, drive fetch_valid=1 with instr 32'hDEADBEEF -> word not stored, count stays 4, overflow=1 and stays 1; a subsequent flush clears it to 0.
- Flush priority: with count=3, assert flush together with fetch_valid=1 and dec_ready=1 -> next cycle count=0, dec_valid=0, dec_instr=NOP; the pushed word is absent from later pops.
- Async reset mid-stream: with count=2, assert reset at 3 ns after a rising edge -> count=0 and dec_valid=0 before the next edge; after release, a push of pc 0x100 appears on dec_pc one cycle later.
